el2_ifu_ic_fill_ctl: RTL
========================

EL2_IFU_IC_FILL_CTL -- requirements
Module: el2_ifu_ic_fill_ctl

Interface
REQ-001 SHALL have parameter BEATS, default 8, 64-bit beats per I$ line; power of 2, 2..16.
REQ-002 SHALL have parameter NUM_WAYS, default 2, I$ ways (1..4).
REQ-003 SHALL have parameter TAG_W, default 3, AXI ID width; TAG_W >= log2(BEATS).
REQ-004 SHALL have parameter LINE_W, default 9, index width of I$ line address.
REQ-005 SHALL declare ports: clk in 1 clock; rst in 1 synchronous active-high reset.
REQ-006 SHALL declare ports: miss_req in 1 miss request; miss_addr in 32 byte address of miss; miss_way in NUM_WAYS one-hot replace way; miss_ready out 1 idle/accepting.
REQ-007 SHALL declare ports: flush in 1 abandon current fill.
REQ-008 SHALL declare ports: ifu_axi_arvalid out 1; ifu_axi_arready in 1; ifu_axi_arid out TAG_W; ifu_axi_araddr out 32.
REQ-009 SHALL declare ports: ifu_axi_rvalid in 1; ifu_axi_rready out 1; ifu_axi_rid in TAG_W; ifu_axi_rdata in 64; ifu_axi_rresp in 2.
REQ-010 SHALL declare ports: ic_wr_en out NUM_WAYS; ic_wr_addr out LINE_W line index; ic_wr_data out 64*BEATS full line.
REQ-011 SHALL declare ports: crit_valid out 1; crit_data out 64 critical beat; fill_done out 1; bus_error out 1; pmu_bus_trxn out 1.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, WRITE, DRAIN.
REQ-013 SHALL set miss_ready = (state==IDLE); accept miss on miss_req & miss_ready & ~flush; capture line base miss_addr[31:log2(BEATS)+3], crit beat c = miss_addr[log2(BEATS)+2:3], way, index; go ISSUE.
REQ-014 ISSUE: SHALL drive ifu_axi_arvalid=1, one single-beat request per beat; k-th request (k=0..BEATS-1) beat b=(c+k) mod BEATS, araddr={base,b,3'b000}, arid=b zero-extended.
REQ-015 SHALL hold arvalid/araddr/arid stable until arready; advance k only on arvalid&arready; pmu_bus_trxn=1 on that cycle.
REQ-016 SHALL go ISSUE->WAIT on handshake of k=BEATS-1; first arvalid in cycle after acceptance.
REQ-017 SHALL tie ifu_axi_rready=1; accept responses in any order; beat index = rid[log2(BEATS)-1:0]; store rdata in line buffer slot, set valid bit, OR rresp!=0 into sticky error flag.
REQ-018 SHALL ignore rvalid in IDLE and WRITE.
REQ-019 SHALL pulse crit_valid one cycle after response for beat c with rresp==0, crit_data=that rdata, only in ISSUE/WAIT.
REQ-020 SHALL go to WRITE when all BEATS valid bits set (ISSUE or WAIT, incl. same-cycle last issue+last response); WRITE lasts one cycle.
REQ-021 WRITE without error: ic_wr_en=miss_way, ic_wr_addr=index, ic_wr_data=buffer (beat j at bits 64j+63:64j), fill_done=1; then IDLE.
REQ-022 WRITE with error: ic_wr_en=0, bus_error=1, fill_done=1; then IDLE.
REQ-023 flush in ISSUE/WAIT: SHALL deassert arvalid next cycle unless handshake occurs same cycle (counts as issued), go DRAIN.
REQ-024 DRAIN: SHALL count responses, discard data, no crit_valid/fill_done/bus_error; IDLE when responses == issued requests.
REQ-025 SHALL let flush in WRITE complete the write; flush in IDLE/DRAIN no effect.
REQ-026 SHALL keep issued and received counters of log2(BEATS)+1 bits, no wrap; clear valid bits and error flag on acceptance.
REQ-027 SHALL register all outputs except miss_ready and ifu_axi_rready.

Reset
REQ-028 rst=1 SHALL force IDLE, counters/valid/error clear; all outputs 0 except miss_ready=1, ifu_axi_rready=1; rst mid-fill abandons without DRAIN.

Verification
REQ-029 BEATS=8, miss_addr=0x0000_1238 (c=7), arready=1 -> araddr 0x1238,0x1200,...,0x1230, arid 7,0..6; in-order OK responses -> crit_valid with beat 7 data, one WRITE cycle, fill_done=1.
REQ-030 Responses in reverse rid order -> ic_wr_data slot j equals data returned with rid j; single ic_wr_en pulse on miss_way.
REQ-031 Beat 3 rresp=2'b10 -> ic_wr_en stays 0, bus_error=1 and fill_done=1 same cycle.
REQ-032 flush after 3 handshakes, 1 response returned -> arvalid low next cycle; miss_ready stays 0 until 2 more responses; no fill_done.
REQ-033 arready low 5 cycles on beat 2 -> araddr/arid stable; pmu_bus_trxn exactly 8 pulses per fill.
REQ-034 rst asserted in WAIT -> next cycle miss_ready=1, all other outputs 0; late responses ignored.

Source files
------------

// File: rtl/el2_ifu_ic_fill_ctl.sv
// el2_ifu_ic_fill_ctl
//
// Instruction-cache line fill controller. A miss is accepted while idle, then the
// line is fetched as BEATS single-beat AXI reads issued critical-beat first and
// wrapping around the line. Read responses may return in any order; each one is
// steered into the line buffer by its read ID. The critical beat is forwarded to
// the fetch pipe as soon as it arrives cleanly. When every beat is present the
// line is written into the replacement way in a single WRITE cycle, unless any
// beat came back with an error, in which case the write is suppressed and
// bus_error is raised. A flush abandons the fill; the controller then sits in
// DRAIN until every read already issued has been answered, so no stale response
// can leak into the next fill.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   miss_req/addr/way     miss request, byte address, one-hot replacement way
//   miss_ready            high while idle and able to accept a miss
//   flush                 abandon the current fill
//   ifu_axi_ar*           read address channel (one beat per request)
//   ifu_axi_r*            read data channel (rready tied high)
//   ic_wr_en/addr/data    line write into the data array (one cycle)
//   crit_valid/crit_data  critical beat bypass, one-cycle pulse
//   fill_done             fill finished (clean or with error)
//   bus_error             fill finished with at least one error response
//   pmu_bus_trxn          one pulse per accepted read address
//   dbg_state             current controller state
//
// Handshake rule: a transfer happens on a rising edge where valid and ready are
// both high; once raised, arvalid and its payload hold until that edge.

module el2_ifu_ic_fill_ctl #(
  parameter int BEATS    = 8,
  parameter int NUM_WAYS = 2,
  parameter int TAG_W    = 3,
  parameter int LINE_W   = 9
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  miss_req,
  input  logic [31:0]           miss_addr,
  input  logic [NUM_WAYS-1:0]   miss_way,
  output logic                  miss_ready,

  input  logic                  flush,

  output logic                  ifu_axi_arvalid,
  input  logic                  ifu_axi_arready,
  output logic [TAG_W-1:0]      ifu_axi_arid,
  output logic [31:0]           ifu_axi_araddr,

  input  logic                  ifu_axi_rvalid,
  output logic                  ifu_axi_rready,
  input  logic [TAG_W-1:0]      ifu_axi_rid,
  input  logic [63:0]           ifu_axi_rdata,
  input  logic [1:0]            ifu_axi_rresp,

  output logic [NUM_WAYS-1:0]   ic_wr_en,
  output logic [LINE_W-1:0]     ic_wr_addr,
  output logic [64*BEATS-1:0]   ic_wr_data,

  output logic                  crit_valid,
  output logic [63:0]           crit_data,
  output logic                  fill_done,
  output logic                  bus_error,
  output logic                  pmu_bus_trxn,

  output logic [2:0]            dbg_state
);

  localparam int BW     = $clog2(BEATS);
  localparam int BASE_W = 32 - BW - 3;
  localparam int CNT_W  = BW + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                state;

  // Captured miss context
  logic [BASE_W-1:0]     base_q;
  logic [BW-1:0]         crit_q;
  logic [NUM_WAYS-1:0]   way_q;
  logic [LINE_W-1:0]     index_q;

  // Beat currently presented on the address channel
  logic [BW-1:0]         beat_q;
  logic [BW-1:0]         beat_inc;

  // Issued / received counts; one extra bit so a full line never wraps to 0
  logic [CNT_W-1:0]      issued_q;
  logic [CNT_W-1:0]      received_q;
  logic [CNT_W-1:0]      received_nxt;

  // Line buffer with per-beat valid bits and a sticky error flag
  logic [BEATS-1:0]      valid_q;
  logic [BEATS-1:0]      valid_nxt;
  logic                  err_q;
  logic                  err_nxt;
  logic [64*BEATS-1:0]   line_q;
  logic [64*BEATS-1:0]   line_nxt;

  logic                  ar_hs;
  logic                  fill_live;
  logic                  rsp_fill;
  logic [BW-1:0]         rsp_beat;

  // Address bits below the beat and any rid bits above the beat index carry no
  // information for the fill.
  logic                  unused_bits;
  assign unused_bits = ^{miss_addr[2:0], ifu_axi_rid};

  assign miss_ready     = (state == IDLE);
  assign ifu_axi_rready = 1'b1;
  assign dbg_state      = state;

  assign ar_hs     = ifu_axi_arvalid & ifu_axi_arready;
  assign fill_live = (state == ISSUE) || (state == WAIT);
  assign rsp_fill  = ifu_axi_rvalid & fill_live;
  assign rsp_beat  = ifu_axi_rid[BW-1:0];
  assign beat_inc  = beat_q + 1'b1;   // wraps modulo BEATS by width

  // Buffer contents as they will be after this edge. The WRITE decision and the
  // written line both use these, so a response arriving in the same cycle as
  // the last issue still completes the line without an extra cycle.
  always_comb begin
    valid_nxt    = valid_q;
    err_nxt      = err_q;
    line_nxt     = line_q;
    received_nxt = received_q;
    if (ifu_axi_rvalid && (fill_live || (state == DRAIN))) begin
      received_nxt = received_q + CNT_W'(1);
    end
    if (rsp_fill) begin
      valid_nxt[rsp_beat]                = 1'b1;
      err_nxt                            = err_q | (ifu_axi_rresp != 2'b00);
      line_nxt[int'(rsp_beat)*64 +: 64]  = ifu_axi_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      base_q          <= '0;
      crit_q          <= '0;
      way_q           <= '0;
      index_q         <= '0;
      beat_q          <= '0;
      issued_q        <= '0;
      received_q      <= '0;
      valid_q         <= '0;
      err_q           <= 1'b0;
      line_q          <= '0;
      ifu_axi_arvalid <= 1'b0;
      ifu_axi_arid    <= '0;
      ifu_axi_araddr  <= '0;
      ic_wr_en        <= '0;
      ic_wr_addr      <= '0;
      ic_wr_data      <= '0;
      crit_valid      <= 1'b0;
      crit_data       <= '0;
      fill_done       <= 1'b0;
      bus_error       <= 1'b0;
      pmu_bus_trxn    <= 1'b0;
    end else begin
      // Pulse outputs default low
      crit_valid   <= 1'b0;
      fill_done    <= 1'b0;
      bus_error    <= 1'b0;
      ic_wr_en     <= '0;
      pmu_bus_trxn <= 1'b0;

      valid_q    <= valid_nxt;
      err_q      <= err_nxt;
      line_q     <= line_nxt;
      received_q <= received_nxt;

      if (ar_hs) begin
        issued_q     <= issued_q + CNT_W'(1);
        pmu_bus_trxn <= 1'b1;
      end

      // Critical beat bypass: only clean data is forwarded
      if (rsp_fill && (rsp_beat == crit_q) && (ifu_axi_rresp == 2'b00)) begin
        crit_valid <= 1'b1;
        crit_data  <= ifu_axi_rdata;
      end

      case (state)
        IDLE: begin
          if (miss_req && !flush) begin
            base_q          <= miss_addr[31:BW+3];
            crit_q          <= miss_addr[BW+2:3];
            way_q           <= miss_way;
            index_q         <= miss_addr[BW+3 +: LINE_W];
            beat_q          <= miss_addr[BW+2:3];
            issued_q        <= '0;
            received_q      <= '0;
            valid_q         <= '0;
            err_q           <= 1'b0;
            ifu_axi_arvalid <= 1'b1;
            ifu_axi_araddr  <= {miss_addr[31:BW+3], miss_addr[BW+2:3], 3'b000};
            ifu_axi_arid    <= TAG_W'(miss_addr[BW+2:3]);
            state           <= ISSUE;
          end
        end

        ISSUE, WAIT: begin
          if (flush) begin
            // A handshake in this same cycle is already counted in issued_q
            ifu_axi_arvalid <= 1'b0;
            state           <= DRAIN;
          end else if (&valid_nxt) begin
            ifu_axi_arvalid <= 1'b0;
            fill_done       <= 1'b1;
            bus_error       <= err_nxt;
            ic_wr_en        <= err_nxt ? '0 : way_q;
            ic_wr_addr      <= index_q;
            ic_wr_data      <= line_nxt;
            state           <= WRITE;
          end else if ((state == ISSUE) && ar_hs) begin
            if (issued_q == CNT_W'(BEATS-1)) begin
              ifu_axi_arvalid <= 1'b0;
              state           <= WAIT;
            end else begin
              beat_q          <= beat_inc;
              ifu_axi_araddr  <= {base_q, beat_inc, 3'b000};
              ifu_axi_arid    <= TAG_W'(beat_inc);
            end
          end
        end

        WRITE: begin
          // Write outputs were presented on entry; flush here is ignored
          state <= IDLE;
        end

        DRAIN: begin
          if (received_nxt == issued_q) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
